// File: rtl/irq_timer_ctrl.sv
// Memory-mapped reload timer and three-source interrupt controller.
// The controller holds off irq while a handler is in service, from irq_ack until irq_ret.
module irq_timer_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx_done,
    input  logic        uart_tx_done,
    input  logic        irq_ack,
    input  logic        irq_ret,
    output logic        irq
);

    localparam int unsigned DW   = 32;
    localparam int unsigned NSRC = 3;

    localparam logic [7:0] OFF_TH     = 8'h00;
    localparam logic [7:0] OFF_TL     = 8'h04;
    localparam logic [7:0] OFF_TCON   = 8'h08;
    localparam logic [7:0] OFF_IEN    = 8'h0C;
    localparam logic [7:0] OFF_IPEND  = 8'h10;
    localparam logic [7:0] OFF_ICAUSE = 8'h14;

    typedef enum logic {
        ST_IDLE,
        ST_SERVICE
    } state_t;

    state_t          state, state_next;
    logic [DW-1:0]   th, tl, tl_next;
    logic            run;
    logic [NSRC-1:0] ien, ipend, ipend_next;
    logic [1:0]      cause, cause_next, sel;
    logic            rx_q, tx_q;

    logic            hit;
    logic            wr_th, wr_tl, wr_tcon, wr_ien, wr_ipend;
    logic            timer_ev;
    logic [NSRC-1:0] events, active, w1c, ack_clr;
    logic            in_service, ack_take, ret_take;

    assign hit      = (addr[31:8] == BASE_ADDR[31:8]);
    assign wr_th    = wr && hit && (addr[7:0] == OFF_TH);
    assign wr_tl    = wr && hit && (addr[7:0] == OFF_TL);
    assign wr_tcon  = wr && hit && (addr[7:0] == OFF_TCON);
    assign wr_ien   = wr && hit && (addr[7:0] == OFF_IEN);
    assign wr_ipend = wr && hit && (addr[7:0] == OFF_IPEND);

    // Timer: a CPU write to TL overrides both increment and reload.
    always_comb begin
        tl_next  = tl;
        timer_ev = 1'b0;
        if (wr_tl) begin
            tl_next = wdata;
        end else if (run) begin
            if (tl == 32'hFFFFFFFF) begin
                tl_next  = th;
                timer_ev = 1'b1;
            end else begin
                tl_next = tl + 32'd1;
            end
        end
    end

    assign in_service = (state == ST_SERVICE);
    assign events     = {uart_tx_done & ~tx_q, uart_rx_done & ~rx_q, timer_ev};
    assign active     = ipend & ien;
    assign irq        = (|active) & ~in_service;
    assign ack_take   = irq_ack & irq;
    assign ret_take   = irq_ret & in_service;

    // Fixed priority: timer > rx > tx.
    always_comb begin
        sel = 2'd2;
        if (active[0]) begin
            sel = 2'd0;
        end else if (active[1]) begin
            sel = 2'd1;
        end
    end

    // New events win over W1C and ack clears of the same bit.
    always_comb begin
        w1c        = wr_ipend ? wdata[NSRC-1:0] : '0;
        ack_clr    = ack_take ? NSRC'(3'b001 << sel) : '0;
        ipend_next = (ipend & ~w1c & ~ack_clr) | events;
    end

    always_comb begin
        state_next = state;
        cause_next = cause;
        case (state)
            ST_IDLE: begin
                if (ack_take) begin
                    state_next = ST_SERVICE;
                    cause_next = sel;
                end
            end
            ST_SERVICE: begin
                if (ret_take) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cause <= 2'd0;
            th    <= '0;
            tl    <= '0;
            run   <= 1'b0;
            ien   <= '0;
            ipend <= '0;
            rx_q  <= 1'b0;
            tx_q  <= 1'b0;
        end else begin
            state <= state_next;
            cause <= cause_next;
            tl    <= tl_next;
            ipend <= ipend_next;
            rx_q  <= uart_rx_done;
            tx_q  <= uart_tx_done;
            if (wr_th)   th  <= wdata;
            if (wr_tcon) run <= wdata[0];
            if (wr_ien)  ien <= wdata[NSRC-1:0];
        end
    end

    // Read mux; unmapped offsets and other windows read zero.
    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            case (addr[7:0])
                OFF_TH:     rdata = th;
                OFF_TL:     rdata = tl;
                OFF_TCON:   rdata = {31'd0, run};
                OFF_IEN:    rdata = {29'd0, ien};
                OFF_IPEND:  rdata = {29'd0, ipend};
                OFF_ICAUSE: rdata = {in_service, 29'd0, cause};
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed self-checking bench for irq_timer_ctrl.
module tb_irq_timer_ctrl;

    localparam logic [31:0] A_TH     = 32'h40000000;
    localparam logic [31:0] A_TL     = 32'h40000004;
    localparam logic [31:0] A_TCON   = 32'h40000008;
    localparam logic [31:0] A_IEN    = 32'h4000000C;
    localparam logic [31:0] A_IPEND  = 32'h40000010;
    localparam logic [31:0] A_ICAUSE = 32'h40000014;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        uart_rx_done, uart_tx_done, irq_ack, irq_ret, irq;

    int checks = 0;
    int errors = 0;

    irq_timer_ctrl #(.BASE_ADDR(32'h40000000)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .uart_rx_done(uart_rx_done), .uart_tx_done(uart_tx_done),
        .irq_ack(irq_ack), .irq_ret(irq_ret), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick(1);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        #1;
        d = rdata;
        rd = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        irq_ret = 1'b1; tick(1); irq_ret = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] offs [6];
        offs = '{A_TH, A_TL, A_TCON, A_IEN, A_IPEND, A_ICAUSE};
        for (int i = 0; i < 6; i++) begin
            bus_read(offs[i], v);
            checks++;
            if (v !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", i, v); end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    endtask

    task automatic test_timer();
        logic [31:0] v;
        bus_write(A_TH, 32'hFFFFFFFC);
        bus_write(A_TL, 32'hFFFFFFFE);
        bus_write(A_IEN, 32'd1);
        bus_write(A_TCON, 32'd1);
        bus_read(A_TL, v);
        checks++;
        if (v !== 32'hFFFFFFFE) begin errors++; $display("FAIL timer_start got %h want FFFFFFFE", v); end
        tick(1);
        bus_read(A_TL, v);
        checks++;
        if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL timer_inc got %h want FFFFFFFF", v); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL timer_irq_early got %b want 0", irq); end
        tick(1);
        bus_read(A_TL, v);
        checks++;
        if (v !== 32'hFFFFFFFC) begin errors++; $display("FAIL timer_reload got %h want FFFFFFFC", v); end
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL timer_ipend got %h want 1", v); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL timer_irq got %b want 1", irq); end
        tick(4);
        bus_read(A_TL, v);
        checks++;
        if (v !== 32'hFFFFFFFC) begin errors++; $display("FAIL timer_rewrap got %h want FFFFFFFC", v); end
        bus_write(A_TCON, 32'd0);
        bus_write(A_IPEND, 32'd7);
        bus_write(A_IEN, 32'd0);
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL timer_cleanup got %h want 0", v); end
    endtask

    task automatic test_w1c_race();
        logic [31:0] v;
        bus_write(A_TH, 32'd0);
        bus_write(A_TL, 32'hFFFFFFFF);
        bus_write(A_TCON, 32'd1);
        bus_write(A_TL, 32'h12345678);   // coincides with would-be overflow
        bus_read(A_TL, v);
        checks++;
        if (v !== 32'h12345678) begin errors++; $display("FAIL tl_write_wins got %h want 12345678", v); end
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL tl_write_no_event got %h want 0", v); end
        bus_write(A_TL, 32'hFFFFFFFF);
        tick(1);
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL race_setup got %h want 1", v); end
        bus_write(A_TL, 32'hFFFFFFFF);
        bus_write(A_IPEND, 32'd1);       // W1C on the overflow edge
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL w1c_race got %h want 1", v); end
        bus_read(A_TL, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL race_reload got %h want 0", v); end
        bus_write(A_TCON, 32'd0);
        bus_write(A_IPEND, 32'd1);
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL w1c_plain got %h want 0", v); end
        tick(3);
        bus_read(A_TL, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL timer_frozen got %h want 1", v); end
    endtask

    task automatic test_priority_ack();
        logic [31:0] v;
        bus_write(A_IEN, 32'd7);
        uart_rx_done = 1'b1; uart_tx_done = 1'b1;
        tick(1);
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd6) begin errors++; $display("FAIL uart_events got %h want 6", v); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL uart_irq got %b want 1", irq); end
        pulse_ack();
        bus_read(A_ICAUSE, v);
        checks++;
        if (v !== 32'h80000001) begin errors++; $display("FAIL ack1_cause got %h want 80000001", v); end
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd4) begin errors++; $display("FAIL ack1_ipend got %h want 4", v); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL ack1_irq got %b want 0", irq); end
        pulse_ret();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL ret1_irq got %b want 1", irq); end
        bus_read(A_ICAUSE, v);
        checks++;
        if (v !== 32'h00000001) begin errors++; $display("FAIL ret1_cause got %h want 00000001", v); end
        pulse_ack();
        bus_read(A_ICAUSE, v);
        checks++;
        if (v !== 32'h80000002) begin errors++; $display("FAIL ack2_cause got %h want 80000002", v); end
        uart_rx_done = 1'b0;
        tick(1);
        uart_rx_done = 1'b1;
        tick(1);
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL rx_in_service got %h want 2", v); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_in_service got %b want 0", irq); end
        irq_ack = 1'b1; irq_ret = 1'b1;
        tick(1);
        irq_ack = 1'b0; irq_ret = 1'b0;
        bus_read(A_ICAUSE, v);
        checks++;
        if (v !== 32'h00000002) begin errors++; $display("FAIL ack_ret_cause got %h want 00000002", v); end
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL ack_ret_ipend got %h want 2", v); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL ack_ret_irq got %b want 1", irq); end
        pulse_ack();
        pulse_ret();
        tick(3);
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL level_once got %h want 0", v); end
        uart_rx_done = 1'b0; uart_tx_done = 1'b0;
        tick(1);
    endtask

    task automatic test_masking();
        logic [31:0] v;
        bus_write(A_IEN, 32'd0);
        uart_tx_done = 1'b1;
        tick(1);
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd4) begin errors++; $display("FAIL mask_ipend got %h want 4", v); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq got %b want 0", irq); end
        pulse_ack();
        bus_read(A_ICAUSE, v);
        checks++;
        if (v !== 32'h00000001) begin errors++; $display("FAIL ack_ignored got %h want 00000001", v); end
        bus_write(A_IEN, 32'd4);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq got %b want 1", irq); end
        pulse_ack();
        bus_read(A_ICAUSE, v);
        checks++;
        if (v !== 32'h80000002) begin errors++; $display("FAIL unmask_cause got %h want 80000002", v); end
        pulse_ret();
        uart_tx_done = 1'b0;
        tick(1);
    endtask

    task automatic test_decode();
        logic [31:0] v;
        bus_write(A_TH, 32'hA5A50000);
        bus_write(32'h40000100, 32'hDEADBEEF);
        bus_write(32'h40000018, 32'hFFFFFFFF);
        bus_read(A_TH, v);
        checks++;
        if (v !== 32'hA5A50000) begin errors++; $display("FAIL decode_th got %h want A5A50000", v); end
        bus_read(A_IEN, v);
        checks++;
        if (v !== 32'd4) begin errors++; $display("FAIL decode_ien got %h want 4", v); end
        bus_read(32'h40000100, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL decode_rd100 got %h want 0", v); end
        bus_read(32'h40000018, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL decode_rd18 got %h want 0", v); end
        addr = A_TH; rd = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'd0) begin errors++; $display("FAIL rd_low got %h want 0", rdata); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        bus_write(A_IEN, 32'd1);
        bus_write(A_TL, 32'hFFFFFFFF);
        bus_write(A_TCON, 32'd1);
        tick(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b want 1", irq); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got %b want 0", irq); end
        bus_read(A_TCON, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL mid_reset_tcon got %h want 0", v); end
        bus_read(A_IPEND, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL mid_reset_ipend got %h want 0", v); end
        reset = 1'b1;
        tick(2);
        bus_read(A_TL, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL post_reset_tl got %h want 0", v); end
    endtask

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        uart_rx_done = 1'b0; uart_tx_done = 1'b0; irq_ack = 1'b0; irq_ret = 1'b0;
        #12;
        test_reset();
        reset = 1'b1;
        tick(1);
        test_timer();
        test_w1c_race();
        test_priority_ack();
        test_masking();
        test_decode();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
